// File: rtl/cache_switch_pkg.sv
// Shared types and constants for the cache-bank switch controller.
// CACHE_SWITCH_FLUSH_EN (optional) enables the FLUSH write-back phase in the controller.
package cache_switch_pkg;
  localparam int         CACHE_ID_W    = 3;
  localparam logic [6:0] SWITCH_OPCODE = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    FLUSH  = 2'd2,
    SWITCH = 2'd3
  } state_e;

  function automatic logic id_in_range(input logic [CACHE_ID_W-1:0] id, input int num);
    return int'(id) < num;
  endfunction
endpackage

// File: rtl/cache_switch_ctrl_if.sv
// Pipeline <-> cache-switch controller signal bundle.
// master = pipeline/cache side, slave = controller.
interface cache_switch_ctrl_if;
  import cache_switch_pkg::*;

  logic                  switch_cache_w;
  logic [CACHE_ID_W-1:0] new_cache_id;
  logic                  mem_busy;
  logic                  flush_done;
  logic                  stall;
  logic                  flush_req;
  logic [CACHE_ID_W-1:0] cache_sel;
  logic                  switch_ack;
  logic                  id_err;
  logic [15:0]           switch_cnt;

  modport master (
    output switch_cache_w, new_cache_id, mem_busy, flush_done,
    input  stall, flush_req, cache_sel, switch_ack, id_err, switch_cnt
  );

  modport slave (
    input  switch_cache_w, new_cache_id, mem_busy, flush_done,
    output stall, flush_req, cache_sel, switch_ack, id_err, switch_cnt
  );
endinterface

// File: rtl/cache_switch_ctrl_drain_timer.sv
// Down-counter that enforces the minimum pipeline drain time; saturates at zero.
module drain_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                 cnt_d = load_val_i;
    else if (dec_i && cnt_q != '0) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/cache_switch_ctrl.sv
// Cache-bank switch controller: drains the pipeline, optionally flushes the active
// bank (CACHE_SWITCH_FLUSH_EN), then swaps cache_sel and pulses switch_ack.
module cache_switch_ctrl
  import cache_switch_pkg::*;
#(
  parameter int NUM_CACHES   = 4,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  cache_switch_ctrl_if.slave  bus
);
  localparam int TMR_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_e                state_q, state_d;
  logic [CACHE_ID_W-1:0] sel_q, sel_d, tgt_q, tgt_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  req_valid, req_bad;
  logic                  tmr_load, tmr_dec, tmr_zero;
  logic                  stall_c, flush_c, ack_c;

  assign req_valid = bus.switch_cache_w &&  id_in_range(bus.new_cache_id, NUM_CACHES);
  assign req_bad   = bus.switch_cache_w && !id_in_range(bus.new_cache_id, NUM_CACHES);

  drain_timer #(.W(TMR_W)) u_drain_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (tmr_load),
    .load_val_i (TMR_W'(DRAIN_CYCLES - 1)),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    err_d    = 1'b0;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    stall_c  = 1'b0;
    flush_c  = 1'b0;
    ack_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_bad) begin
          err_d = 1'b1;
        end else if (req_valid) begin
          stall_c = 1'b1;
          tgt_d   = bus.new_cache_id;
          if (bus.new_cache_id == sel_q) begin
            state_d = SWITCH;
          end else begin
            state_d  = DRAIN;
            tmr_load = 1'b1;
          end
        end
      end
      DRAIN: begin
        stall_c = 1'b1;
        tmr_dec = 1'b1;
        if (tmr_zero && !bus.mem_busy) begin
`ifdef CACHE_SWITCH_FLUSH_EN
          state_d = FLUSH;
`else
          state_d = SWITCH;
`endif
        end
      end
      FLUSH: begin
`ifdef CACHE_SWITCH_FLUSH_EN
        stall_c = 1'b1;
        flush_c = 1'b1;
        if (bus.flush_done) state_d = SWITCH;
`else
        state_d = IDLE;
`endif
      end
      SWITCH: begin
        stall_c = 1'b1;
        ack_c   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // cache_sel moves on the edge that enters SWITCH; only real bank changes are counted
    if (state_d == SWITCH && state_q != SWITCH) begin
      sel_d = tgt_d;
      if (tgt_d != sel_q) cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      tgt_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

`ifndef CACHE_SWITCH_FLUSH_EN
  logic unused_flush_done;
  assign unused_flush_done = bus.flush_done;
`endif

  assign bus.stall      = stall_c;
  assign bus.flush_req  = flush_c;
  assign bus.cache_sel  = sel_q;
  assign bus.switch_ack = ack_c;
  assign bus.id_err     = err_q;
  assign bus.switch_cnt = cnt_q;
endmodule

// File: tb/tb_cache_switch_ctrl.sv
// Randomized self-checking bench for cache_switch_ctrl against a cycle-count model.
module tb_cache_switch_ctrl;
  localparam int NC = 4;
  localparam int DC = 3;
`ifdef CACHE_SWITCH_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  logic [2:0]  m_sel;
  logic [15:0] m_cnt;

  cache_switch_ctrl_if bus();

  cache_switch_ctrl #(.NUM_CACHES(NC), .DRAIN_CYCLES(DC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // One switch request; expected timing comes from the rules: drain lasts
  // max(DRAIN_CYCLES, busy+1), flush lasts flat+1, then one SWITCH cycle.
  task automatic do_switch(input logic [2:0] id, input int busy, input int flat, input string tag);
    int stall_n = 0, fl_n = 0, ack_n = 0, ack_k = 0, dlen, exp_len, exp_fl;
    bit diff, sel_bad = 0, err_seen = 0;
    diff    = (id != m_sel);
    dlen    = diff ? ((busy + 1 > DC) ? busy + 1 : DC) : 0;
    exp_fl  = (diff && FLUSH_EN) ? flat + 1 : 0;
    exp_len = dlen + exp_fl + 1;
    @(posedge clk); #1;
    bus.switch_cache_w = 1'b1; bus.new_cache_id = id;
    @(negedge clk);
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL %s req_stall: got %b expected 1", tag, bus.stall); end
    @(posedge clk); #1;
    bus.switch_cache_w = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      bus.mem_busy = (k <= busy);
      @(negedge clk);
      if (bus.stall !== 1'b1) break;
      stall_n++;
      if (bus.flush_req === 1'b1) begin fl_n++; bus.flush_done = (fl_n >= flat + 1); end
      else bus.flush_done = 1'b0;
      if (bus.switch_ack === 1'b1) begin ack_n++; ack_k = k; if (bus.cache_sel !== id) sel_bad = 1; end
      if (bus.id_err === 1'b1) err_seen = 1;
      @(posedge clk); #1;
    end
    bus.mem_busy = 1'b0; bus.flush_done = 1'b0;
    checks++; if (stall_n != exp_len) begin errors++; $display("FAIL %s stall_len: got %0d expected %0d", tag, stall_n, exp_len); end
    checks++; if (ack_n != 1) begin errors++; $display("FAIL %s ack_pulses: got %0d expected 1", tag, ack_n); end
    checks++; if (ack_k != exp_len) begin errors++; $display("FAIL %s ack_cycle: got %0d expected %0d", tag, ack_k, exp_len); end
    checks++; if (fl_n != exp_fl) begin errors++; $display("FAIL %s flush_len: got %0d expected %0d", tag, fl_n, exp_fl); end
    checks++; if (sel_bad || err_seen) begin errors++; $display("FAIL %s sel_at_ack/id_err: got %0d/%0d expected 0/0", tag, sel_bad, err_seen); end
    m_sel = id;
    if (diff) m_cnt = m_cnt + 16'd1;
    checks++; if (bus.cache_sel !== m_sel) begin errors++; $display("FAIL %s cache_sel: got %0d expected %0d", tag, bus.cache_sel, m_sel); end
    checks++; if (bus.switch_cnt !== m_cnt) begin errors++; $display("FAIL %s switch_cnt: got %0d expected %0d", tag, bus.switch_cnt, m_cnt); end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.switch_cache_w = 1'b0; bus.new_cache_id = '0; bus.mem_busy = 1'b0; bus.flush_done = 1'b0;
    m_sel = '0; m_cnt = '0;
    repeat (3) @(negedge clk);
    checks++; if (bus.cache_sel !== 3'd0) begin errors++; $display("FAIL reset cache_sel: got %0d expected 0", bus.cache_sel); end
    checks++; if (bus.switch_cnt !== 16'd0) begin errors++; $display("FAIL reset switch_cnt: got %0d expected 0", bus.switch_cnt); end
    checks++; if ({bus.stall, bus.flush_req, bus.switch_ack, bus.id_err} !== 4'b0) begin
      errors++; $display("FAIL reset ctl: got %b expected 0000", {bus.stall, bus.flush_req, bus.switch_ack, bus.id_err}); end
    bus.switch_cache_w = 1'b1; bus.new_cache_id = 3'd1;
    #1;
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL reset_valid_req stall: got %b expected 1", bus.stall); end
    bus.switch_cache_w = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL post_reset stall: got %b expected 0", bus.stall); end
  endtask

  task automatic test_bad_id(input logic [2:0] id);
    @(posedge clk); #1;
    bus.switch_cache_w = 1'b1; bus.new_cache_id = id;
    @(negedge clk);
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL bad_id stall: got %b expected 0", bus.stall); end
    @(posedge clk); #1;
    bus.switch_cache_w = 1'b0;
    @(negedge clk);
    checks++; if (bus.id_err !== 1'b1) begin errors++; $display("FAIL bad_id id_err: got %b expected 1", bus.id_err); end
    checks++; if (bus.stall !== 1'b0 || bus.cache_sel !== m_sel) begin
      errors++; $display("FAIL bad_id stall/sel: got %b/%0d expected 0/%0d", bus.stall, bus.cache_sel, m_sel); end
    @(negedge clk);
    checks++; if (bus.id_err !== 1'b0) begin errors++; $display("FAIL bad_id pulse_end: got %b expected 0", bus.id_err); end
  endtask

  task automatic test_flush_ignored();
    @(posedge clk); #1; bus.flush_done = 1'b1;
    @(posedge clk); #1; bus.flush_done = 1'b0;
    @(negedge clk);
    checks++; if ({bus.stall, bus.switch_ack, bus.flush_req} !== 3'b0 || bus.cache_sel !== m_sel) begin
      errors++; $display("FAIL flush_ignored: got %b sel %0d expected 000 sel %0d",
                         {bus.stall, bus.switch_ack, bus.flush_req}, bus.cache_sel, m_sel); end
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 9) < 2) test_bad_id(3'($urandom_range(NC, 7)));
      else do_switch(3'($urandom_range(0, NC - 1)), $urandom_range(0, 8), $urandom_range(0, 3), "random");
    end
  endtask

  task automatic test_reset_mid_switch();
    bit hit = 0;
    @(posedge clk); #1;
    bus.switch_cache_w = 1'b1; bus.new_cache_id = (m_sel == 3'd3) ? 3'd1 : 3'd3;
    @(posedge clk); #1;
    bus.switch_cache_w = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (FLUSH_EN ? (bus.flush_req === 1'b1) : (k == 1)) begin hit = 1; break; end
    end
    checks++; if (!hit) begin errors++; $display("FAIL mid_reset reach_target_state: got 0 expected 1"); end
    reset_n = 1'b0;
    #1;
    checks++; if ({bus.flush_req, bus.stall, bus.switch_ack, bus.id_err} !== 4'b0) begin
      errors++; $display("FAIL mid_reset ctl: got %b expected 0000", {bus.flush_req, bus.stall, bus.switch_ack, bus.id_err}); end
    checks++; if (bus.cache_sel !== 3'd0 || bus.switch_cnt !== 16'd0) begin
      errors++; $display("FAIL mid_reset sel/cnt: got %0d/%0d expected 0/0", bus.cache_sel, bus.switch_cnt); end
    m_sel = '0; m_cnt = '0;
    @(negedge clk); reset_n = 1'b1;
    do_switch(3'd2, 0, 0, "post_mid_reset");
  endtask

  initial begin
    test_reset();
    do_switch(3'd2, 0, 0, "basic_id2");
    do_switch(3'd2, 0, 0, "same_id2");
    test_bad_id(3'd5);
    do_switch(3'd1, 6, 0, "mem_busy6");
    test_flush_ignored();
    do_switch(3'd0, 0, 2, "slow_flush");
    test_random(30);
    test_reset_mid_switch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cache_switch_ctrl.md
CACHE_SWITCH_CTRL -- requirements
Module: cache_switch_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_CACHES, default 4, the number of selectable cache banks (2..8).
REQ-002 The block SHALL have parameter DRAIN_CYCLES, default 3, the minimum pipeline drain cycles before a switch (>=1).
REQ-003 Port clk: input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset_n: input, 1 bit, asynchronous active-low reset.
REQ-005 Port switch_cache_w: input, 1 bit, cache-switch instruction decoded (opcode 1111111) in ID.
REQ-006 Port new_cache_id: input, 3 bits, target bank, from rs1 low bits.
REQ-007 Port mem_busy: input, 1 bit, data cache has an outstanding access.
REQ-008 Port flush_done: input, 1 bit, the cache completed write-back of dirty lines.
REQ-009 Port stall: output, 1 bit, freezes PC and IF/ID.
REQ-010 Port flush_req: output, 1 bit, requests write-back of the active bank.
REQ-011 Port cache_sel: output, 3 bits, the active bank index.
REQ-012 Port switch_ack: output, 1 bit, one-cycle pulse when a switch completes.
REQ-013 Port id_err: output, 1 bit, one-cycle pulse when new_cache_id >= NUM_CACHES.
REQ-014 Port switch_cnt: output, 16 bits, count of completed bank changes.

Function
REQ-015 The FSM SHALL have four states: IDLE, DRAIN, FLUSH, SWITCH.
REQ-016 Requests SHALL be sampled only in IDLE; a request is valid when switch_cache_w=1 and new_cache_id < NUM_CACHES.
REQ-017 In IDLE with switch_cache_w=1 and an out-of-range ID, the block SHALL pulse id_err next cycle, remain in IDLE, and leave stall low.
REQ-018 A valid request with new_cache_id == cache_sel SHALL go IDLE->SWITCH; switch_cnt SHALL NOT increment.
REQ-019 A valid request with a differing ID SHALL latch the target ID and go IDLE->DRAIN, loading the drain counter with DRAIN_CYCLES-1.
REQ-020 In DRAIN the counter SHALL decrement to 0 and hold; DRAIN SHALL exit when counter==0 and mem_busy==0.
REQ-021 FLUSH SHALL hold flush_req=1 until flush_done=1, then go to SWITCH on the next edge; flush_done outside FLUSH SHALL be ignored.
REQ-022 On entry to SWITCH, cache_sel SHALL load the latched ID; in SWITCH, switch_ack SHALL be 1; SWITCH->IDLE unconditionally.
REQ-023 stall SHALL be combinational: 1 in IDLE with a valid request, and 1 in DRAIN, FLUSH and SWITCH.
REQ-024 switch_cnt SHALL increment by 1 on each SWITCH entry that changes cache_sel, wrapping 0xFFFF->0x0000.
REQ-025 Minimum latency for a differing ID (DRAIN_CYCLES=3, mem_busy=0, flush_done immediate) SHALL be request edge to switch_ack of 3+1+1 cycles.

Reset
REQ-026 reset_n=0 SHALL force, at any time including mid-switch: state=IDLE, cache_sel=0, switch_cnt=0, drain counter=0, latched ID=0, and flush_req, switch_ack, id_err=0.
REQ-027 After reset, stall SHALL be 0 unless a valid request is present.

Configuration
REQ-028 With macro CACHE_SWITCH_FLUSH_EN defined, FLUSH SHALL be used as specified.
REQ-029 Without CACHE_SWITCH_FLUSH_EN, DRAIN SHALL go directly to SWITCH, flush_req SHALL be tied to 0, and flush_done SHALL be unused.

Structure
REQ-030 State encoding (IDLE=0, DRAIN=1, FLUSH=2, SWITCH=3), the CACHE_ID_W=3 constant, and the switch opcode 7'b1111111 SHALL reside in a shared package cache_switch_pkg.
REQ-031 The drain counter SHALL be a sub-module named drain_timer (load, decrement, zero flag).

Verification
REQ-032 Reset, then switch_cache_w=1 with id=2, mem_busy=0, flush_done one cycle after flush_req -> stall for 5 cycles, cache_sel=2, switch_ack one pulse, switch_cnt=1.
REQ-033 With cache_sel=2, request id=2 -> a single SWITCH cycle with stall=1 and switch_ack=1, flush_req never 1, switch_cnt unchanged.
REQ-034 Request id=5 with NUM_CACHES=4 -> id_err pulse, stall=0, cache_sel unchanged.
REQ-035 mem_busy=1 for 6 cycles during DRAIN -> DRAIN held until mem_busy falls, then FLUSH entered.
REQ-036 reset_n asserted during FLUSH -> same cycle: flush_req=0, cache_sel=0, stall=0.
REQ-037 Build without CACHE_SWITCH_FLUSH_EN, request id=1 -> flush_req stays 0, switch_ack 4 cycles after the request edge.
